// File: rtl/wb_sram_bist.sv
// -----------------------------------------------------------------------------
// wb_sram_bist -- Wishbone classic initiator running a 3-element March test
// over a DEPTH x 32 SRAM slave:
//   M0_W : ascending,  write P
//   M1_R : ascending,  read expect P, then M1_W: write ~P at the same index
//   M2_R : descending, read expect ~P
// Every access is preceded by exactly one cycle with cyc/stb low. The access
// completes on the first rising edge that sees wbm_ack_i while stb is high.
// The first read mismatch ends the test: the index and read data are latched,
// pass_o stays 0, and the FSM parks in DONE without issuing another access.
//
// Optional feature: define WB_SRAM_BIST_TIMEOUT_EN to abort an access that
// sees no ack after 16 strobe cycles (fail_data_o = 32'hDEAD_BEEF).
//
// Ports
//   wb_clk_i, wb_rst_ni       : clock, synchronous active-low reset
//   start_i                   : one-cycle request, honoured in IDLE/DONE only
//   busy_o, done_o, pass_o    : status (pass_o meaningful while done_o=1)
//   fail_addr_o, fail_data_o  : word index / read data of first mismatch
//   wbm_*                     : Wishbone classic master port
// -----------------------------------------------------------------------------
module wb_sram_bist #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] PATTERN   = 32'h5555_AAAA,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [31:0]   fail_data_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic [31:0]   wbm_dat_i
);

  typedef enum logic [2:0] {IDLE, M0_W, M1_R, M1_W, M2_R, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          stb_q, stb_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]   fail_data_q, fail_data_d;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
  logic [3:0]    tmo_q, tmo_d;   // stalled strobe cycles seen so far
`endif

  logic          last_up, last_dn, rd_bad;
  logic [31:0]   rd_exp;

  assign last_up = (idx_q == AW'(DEPTH - 1));
  assign last_dn = (idx_q == '0);
  assign rd_exp  = (state_q == M1_R) ? PATTERN : ~PATTERN;
  assign rd_bad  = (wbm_dat_i != rd_exp);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stb_q       <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stb_q       <= stb_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stb_d       = stb_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
    tmo_d       = (stb_q && !wbm_ack_i) ? tmo_q + 4'd1 : 4'd0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = M0_W;
          idx_d       = '0;
          stb_d       = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      default: begin
        // stb low here is the mandatory idle cycle; raise it next edge
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wbm_ack_i) begin
          stb_d = 1'b0;
          case (state_q)
            M0_W: begin
              if (last_up) begin
                state_d = M1_R;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + AW'(1);
              end
            end
            M1_R: begin
              if (rd_bad) begin
                fail_addr_d = idx_q;
                fail_data_d = wbm_dat_i;
                state_d     = DONE;
              end else begin
                state_d = M1_W;
              end
            end
            M1_W: begin
              if (last_up) begin
                state_d = M2_R;
                idx_d   = AW'(DEPTH - 1);
              end else begin
                state_d = M1_R;
                idx_d   = idx_q + AW'(1);
              end
            end
            M2_R: begin
              if (rd_bad) begin
                fail_addr_d = idx_q;
                fail_data_d = wbm_dat_i;
                state_d     = DONE;
              end else if (last_dn) begin
                pass_d  = 1'b1;
                state_d = DONE;
              end else begin
                idx_d = idx_q - AW'(1);
              end
            end
            default: ;
          endcase
        end
`ifdef WB_SRAM_BIST_TIMEOUT_EN
        else if (tmo_q == 4'd15) begin
          // 16th strobe cycle without ack: give up on this access
          stb_d       = 1'b0;
          fail_addr_d = idx_q;
          fail_data_d = 32'hDEAD_BEEF;
          pass_d      = 1'b0;
          state_d     = DONE;
        end
`endif
      end
    endcase
  end

  // Bus outputs are gated by stb so everything reads 0 between accesses.
  assign busy_o      = (state_q == M0_W) || (state_q == M1_R) ||
                       (state_q == M1_W) || (state_q == M2_R);
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign wbm_cyc_o   = stb_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = stb_q && ((state_q == M0_W) || (state_q == M1_W));
  assign wbm_sel_o   = stb_q ? 4'hF : 4'h0;
  assign wbm_adr_o   = stb_q ? BASE_ADDR + (32'(idx_q) << 2) : 32'h0;
  assign wbm_dat_o   = wbm_we_o ? ((state_q == M1_W) ? ~PATTERN : PATTERN) : 32'h0;

endmodule

// File: tb/tb_wb_sram_bist.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_bist -- bench for wb_sram_bist. A Wishbone SRAM slave with
// configurable/random ack latency and an optional stuck-at cell serves the
// DUT. Before each run the expected access list and final status are derived
// from the March algorithm on an abstract memory; one negedge monitor checks
// every bus cycle against that list.
// -----------------------------------------------------------------------------
module tb_wb_sram_bist;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] P     = 32'h5555_AAAA;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          busy_o, done_o, pass_o;
  logic [AW-1:0] fail_addr_o;
  logic [31:0]   fail_data_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;

  wb_sram_bist #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .PATTERN(P)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, edges = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM slave ----------------
  logic [31:0]   mem [DEPTH];
  int            w_min = 0, w_max = 0, w_cur = 0, wcnt = 0;
  longint        lat_sum = 0;
  bit            f_en = 0, f_val = 0;
  int            f_idx = 0, f_bit = 0;
  logic [AW-1:0] sidx;

  function automatic logic [31:0] faulty(input int i, input logic [31:0] d,
                                         input bit en, input int fi, input int fb, input bit fv);
    logic [31:0] r;
    r = d;
    if (en && i == fi) r[fb] = fv;
    return r;
  endfunction

  assign sidx      = AW'((wbm_adr_o - BASE) >> 2);
  assign wbm_dat_i = faulty(int'(sidx), mem[sidx], f_en, f_idx, f_bit, f_val);
  assign wbm_ack_i = wbm_stb_o && (wcnt == w_cur);

  always @(posedge clk) begin
    if (wbm_stb_o && wbm_ack_i) begin
      if (wbm_we_o) mem[sidx] <= wbm_dat_o;
      lat_sum <= lat_sum + longint'(w_cur) + 2;
      wcnt    <= 0;
    end else if (wbm_stb_o) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt  <= 0;
      w_cur <= w_min + int'($urandom_range(0, w_max - w_min));
    end
  end

  // ---------------- reference model ----------------
  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } acc_t;
  acc_t        exp_q[$];
  logic [31:0] mm [DEPTH];
  bit          e_pass;
  logic [31:0] e_faddr, e_fdata;

  task automatic push_acc(input bit we, input int i, input logic [31:0] d);
    acc_t a;
    a.we = we; a.adr = BASE + 32'(i * 4); a.dat = d;
    exp_q.push_back(a);
  endtask

  task automatic build_model();
    bit bad;
    logic [31:0] rd;
    bad = 0;
    exp_q.delete();
    e_pass = 1; e_faddr = 0; e_fdata = 0;
    for (int i = 0; i < DEPTH; i++) begin mm[i] = P; push_acc(1, i, P); end
    for (int i = 0; i < DEPTH && !bad; i++) begin
      push_acc(0, i, 32'h0);
      rd = faulty(i, mm[i], f_en, f_idx, f_bit, f_val);
      if (rd != P) begin bad = 1; e_pass = 0; e_faddr = 32'(i); e_fdata = rd; end
      else begin mm[i] = ~P; push_acc(1, i, ~P); end
    end
    for (int i = DEPTH - 1; i >= 0 && !bad; i--) begin
      push_acc(0, i, 32'h0);
      rd = faulty(i, mm[i], f_en, f_idx, f_bit, f_val);
      if (rd != ~P) begin bad = 1; e_pass = 0; e_faddr = 32'(i); e_fdata = rd; end
    end
  endtask

  // ---------------- bus monitor ----------------
  int          n_acc = 0;
  logic [31:0] last_adr = 0, p_adr = 0, p_dat = 0;
  logic        p_we = 0;
  bit          prev_stall = 0, prev_ack = 0;
  acc_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0; prev_ack = 0;
    end else begin
      if (prev_ack) chk("gap_after_ack", 32'(wbm_stb_o | wbm_cyc_o), 32'h0);
      if (prev_stall) begin
        chk("stb_held_until_ack", 32'(wbm_stb_o), 32'h1);
        chk("stall_adr_stable", wbm_adr_o, p_adr);
        chk("stall_dat_stable", wbm_dat_o, p_dat);
        chk("stall_we_stable", 32'(wbm_we_o), 32'(p_we));
      end
      if (wbm_stb_o) begin
        chk("cyc_with_stb", 32'(wbm_cyc_o), 32'h1);
        chk("sel", 32'(wbm_sel_o), 32'hF);
        chk("busy_during_access", 32'(busy_o), 32'h1);
      end
      if (wbm_stb_o && wbm_ack_i) begin
        chk("access_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("acc_we", 32'(wbm_we_o), 32'(mon_e.we));
          chk("acc_adr", wbm_adr_o, mon_e.adr);
          if (mon_e.we) chk("acc_wdat", wbm_dat_o, mon_e.dat);
          n_acc++;
          last_adr = wbm_adr_o;
        end
      end
      prev_stall = wbm_stb_o && !wbm_ack_i;
      prev_ack   = wbm_stb_o && wbm_ack_i;
      p_adr = wbm_adr_o; p_dat = wbm_dat_o; p_we = wbm_we_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  int     t0 = 0, lat = 0, acc0 = 0;
  longint ls0 = 0;

  task automatic check_all_zero(input string tag);
    chk({tag, "_cyc"}, 32'(wbm_cyc_o), 32'h0);
    chk({tag, "_stb"}, 32'(wbm_stb_o), 32'h0);
    chk({tag, "_we"}, 32'(wbm_we_o), 32'h0);
    chk({tag, "_sel"}, 32'(wbm_sel_o), 32'h0);
    chk({tag, "_adr"}, wbm_adr_o, 32'h0);
    chk({tag, "_dat"}, wbm_dat_o, 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_pass"}, 32'(pass_o), 32'h0);
    chk({tag, "_faddr"}, 32'(fail_addr_o), 32'h0);
    chk({tag, "_fdata"}, fail_data_o, 32'h0);
  endtask

  task automatic start_test();
    build_model();
    acc0 = n_acc; ls0 = lat_sum;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    t0 = edges;
    chk("start_clears_done", 32'(done_o), 32'h0);
    chk("start_clears_pass", 32'(pass_o), 32'h0);
    chk("start_clears_faddr", 32'(fail_addr_o), 32'h0);
    chk("start_clears_fdata", fail_data_o, 32'h0);
    chk("start_sets_busy", 32'(busy_o), 32'h1);
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!done_o && i < limit) begin @(negedge clk); i++; end
    chk("done_within_bound", 32'(done_o), 32'h1);
    lat = edges - t0;
  endtask

  task automatic check_result(input string tag, input int exp_lat);
    int stb_cnt;
    stb_cnt = 0;
    chk({tag, "_pass"}, 32'(pass_o), 32'(e_pass));
    chk({tag, "_faddr"}, 32'(fail_addr_o), e_faddr);
    chk({tag, "_fdata"}, fail_data_o, e_fdata);
    chk({tag, "_all_accesses_seen"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_clear"}, 32'(busy_o), 32'h0);
    repeat (20) begin @(negedge clk); if (wbm_stb_o) stb_cnt++; end
    chk({tag, "_no_access_after_done"}, 32'(stb_cnt), 32'h0);
    chk({tag, "_done_held"}, 32'(done_o), 32'h1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int found, cnt;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_all_zero("idle");

    // zero-wait pass
    w_min = 0; w_max = 0; f_en = 0;
    start_test(); wait_done(30000);
    check_result("pass", int'(lat_sum - ls0));
    chk("pass_latency_lit", 32'(lat), 32'd8192);
    chk("pass_access_count", 32'(n_acc - acc0), 32'd4096);
    chk("pass_last_adr", last_adr, 32'h3000_0000);

    // stuck-at-0 on bit 3 of word 0x155
    f_en = 1; f_idx = 'h155; f_bit = 3; f_val = 0;
    start_test(); wait_done(30000);
    check_result("stuck", int'(lat_sum - ls0));
    chk("stuck_faddr_lit", 32'(fail_addr_o), 32'h155);
    chk("stuck_fdata_lit", fail_data_o, 32'h5555_AAA2);
    chk("stuck_access_count", 32'(n_acc - acc0), 32'd1707);
    chk("stuck_latency_lit", 32'(lat), 32'd3414);

    // 3-cycle ack stall
    f_en = 0; w_min = 3; w_max = 3;
    start_test(); wait_done(30000);
    check_result("stall", int'(lat_sum - ls0));
    chk("stall_latency_lit", 32'(lat), 32'd20480);

    // reset during an M1_W access, then a full run
    w_min = 1; w_max = 1;
    start_test();
    found = 0; cnt = 0;
    while (!found && cnt < 20000) begin
      @(negedge clk); cnt++;
      if (wbm_stb_o && wbm_we_o && wbm_dat_o == ~P && !wbm_ack_i) found = 1;
    end
    chk("m1w_access_reached", 32'(found), 32'h1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #1 check_all_zero("mid_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (wbm_stb_o || busy_o) cnt++; end
    chk("no_resume_after_reset", 32'(cnt), 32'h0);
    w_min = 0; w_max = 0;
    start_test(); wait_done(30000);
    check_result("post_reset", int'(lat_sum - ls0));
    chk("post_reset_latency_lit", 32'(lat), 32'd8192);

    // random stalls, start pulsed during M2_R
    w_min = 0; w_max = 1;
    start_test();
    cnt = 0;
    while ((n_acc - acc0) < 3 * DEPTH + 10 && cnt < 30000) begin @(negedge clk); cnt++; end
    chk("m2r_reached", 32'((n_acc - acc0) >= 3 * DEPTH + 10), 32'h1);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("start_ignored_busy", 32'(busy_o), 32'h1);
    wait_done(30000);
    check_result("rand_stall", int'(lat_sum - ls0));
    chk("rand_stall_access_count", 32'(n_acc - acc0), 32'd4096);

    // random stuck-at cell
    w_min = 0; w_max = 0;
    f_en = 1; f_idx = int'($urandom_range(0, DEPTH - 1));
    f_bit = int'($urandom_range(0, 31)); f_val = 1'($urandom_range(0, 1));
    start_test(); wait_done(30000);
    check_result("rand_fault", int'(lat_sum - ls0));
    chk("rand_fault_at_cell", 32'(fail_addr_o), 32'(f_idx));
    f_en = 0;

`ifdef WB_SRAM_BIST_TIMEOUT_EN
    // slave never acks index 0
    w_min = 100000; w_max = 100000;
    start_test();
    exp_q.delete();
    e_pass = 0; e_faddr = 0; e_fdata = 32'hDEAD_BEEF;
    wait_done(200);
    check_result("timeout", 17);
    w_min = 0; w_max = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, actual incomplete required finished");
    $fatal(1, "watchdog");
  end

endmodule
